// File: rtl/jk_pkg.sv
// Shared mode encodings for the JK mode register.
package jk_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_JK   = 2'b00;
    localparam mode_t MODE_LOAD = 2'b01;
    localparam mode_t MODE_UP   = 2'b10;
    localparam mode_t MODE_DOWN = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK storage cell with asynchronous active-high reset to a per-bit value.
module jk_cell (
    input  logic clk,
    input  logic cl,
    input  logic rst_val,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic r_q;

    always_ff @(posedge clk or posedge cl) begin
        if (cl) begin
            r_q <= rst_val;
        end else if (en) begin
            case ({j, k})
                2'b10:   r_q <= 1'b1;
                2'b01:   r_q <= 1'b0;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q  = r_q;
    assign qb = ~r_q;

endmodule

// File: rtl/jk_mode_reg.sv
// WIDTH-bit register of JK cells with JK, load, up-count and down-count modes,
// terminal-count decode and a sticky wrap flag.
module jk_mode_reg
    import jk_pkg::*;
#(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             cl,
    input  logic             en,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_qb;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_borrow;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_wrap;
    logic             r_ovf;

    // Ripple AND chains: a bit flips when every lower bit is 1 (up) or 0 (down).
    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    for (genvar i = 1; i < WIDTH; i++) begin : g_chain
        assign w_carry[i]  = w_carry[i-1] & w_q[i-1];
        assign w_borrow[i] = w_borrow[i-1] & w_qb[i-1];
    end

    always_comb begin
        w_j = '0;
        w_k = '0;
        case (mode)
            MODE_JK: begin
                w_j = j;
                w_k = k;
            end
            MODE_LOAD: begin
                w_j = d;
                w_k = ~d;
            end
            MODE_UP: begin
                w_j = w_carry;
                w_k = w_carry;
            end
            MODE_DOWN: begin
                w_j = w_borrow;
                w_k = w_borrow;
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk     (clk),
            .cl      (cl),
            .rst_val (RESET_VAL[i]),
            .en      (en),
            .j       (w_j[i]),
            .k       (w_k[i]),
            .q       (w_q[i]),
            .qb      (w_qb[i])
        );
    end

    // tc doubles as the wrap strobe: it is high exactly when the next edge wraps.
    assign w_wrap = en & (((mode == MODE_UP) & (&w_q)) | ((mode == MODE_DOWN) & ~(|w_q)));

    always_ff @(posedge clk or posedge cl) begin
        if (cl) begin
            r_ovf <= 1'b0;
        end else if (w_wrap) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign q   = w_q;
    assign qb  = w_qb;
    assign tc  = w_wrap;
    assign ovf = r_ovf;

endmodule
